// File: rtl/cic_interp_pkg.sv
// Shared CIC width arithmetic so decimator and interpolator datapaths agree on register sizes.
// Revision: 1.0
`default_nettype none

package cic_interp_pkg;

  localparam int DEF_I_WIDTH     = 8;
  localparam int DEF_ORDER       = 5;
  localparam int DEF_INTERP_BITS = 2;

  // Internal width: full growth of ORDER stages at ratio 2**rbits.
  function automatic int cic_width(input int iw, input int order, input int rbits);
    return iw + order * rbits;
  endfunction

  // Interpolator output width: DC gain is R**(ORDER-1), so one stage of growth is never seen.
  function automatic int cic_out_width(input int iw, input int order, input int rbits);
    return iw + (order - 1) * rbits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cic_interp_integrator.sv
// W-bit wrapping accumulator with clock enable and asynchronous active-low clear.
// Revision: 1.0
`default_nettype none

module cic_interp_integrator #(
  parameter int W = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] acc
);

  // Modulo-2**W wrap is relied upon; the final output is exact after truncation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cic_interp.sv
// CIC interpolator: low-rate comb section, zero-stuffing upsampler by 2**INTERP_BITS, high-rate integrators.
// Revision: 1.0
`default_nettype none

module cic_interp
  import cic_interp_pkg::*;
#(
  parameter  int I_WIDTH     = DEF_I_WIDTH,
  parameter  int ORDER       = DEF_ORDER,
  parameter  int INTERP_BITS = DEF_INTERP_BITS,
  localparam int W           = cic_width(I_WIDTH, ORDER, INTERP_BITS),
  localparam int O_WIDTH     = cic_out_width(I_WIDTH, ORDER, INTERP_BITS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic signed [I_WIDTH-1:0] i_data,
  output logic                      o_req,
  output logic signed [O_WIDTH-1:0] o_data,
  output logic                      o_valid
);

  logic        [INTERP_BITS-1:0] phase;
  logic signed [W-1:0]           comb  [0:ORDER];
  logic signed [W-1:0]           integ [0:ORDER];
  logic signed [W-1:0]           up;
  logic                          unused_msbs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase <= '0;
    end else if (i_en) begin
      phase <= phase + 1'b1;
    end
  end

  assign o_req   = i_en && (phase == '0);
  assign comb[0] = {{(W-I_WIDTH){i_data[I_WIDTH-1]}}, i_data};

  // Comb delays advance only at the low rate, i.e. when a sample is accepted.
  for (genvar k = 1; k <= ORDER; k++) begin : g_comb
    logic signed [W-1:0] dly;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        dly <= '0;
      end else if (o_req) begin
        dly <= comb[k-1];
      end
    end

    assign comb[k] = comb[k-1] - dly;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      up <= '0;
    end else if (i_en) begin
      up <= o_req ? comb[ORDER] : '0;
    end
  end

  assign integ[0] = up;

  for (genvar k = 1; k <= ORDER; k++) begin : g_integ
    cic_interp_integrator #(
      .W (W)
    ) u_integ (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (i_en),
      .din   (integ[k-1]),
      .acc   (integ[k])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_en;
      if (i_en) begin
        o_data <= integ[ORDER][O_WIDTH-1:0];
      end
    end
  end

  // Top bits carry only wrap residue; the true result always fits O_WIDTH.
  assign unused_msbs = ^integ[ORDER][W-1:O_WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_cic_interp.sv
// Directed bench for cic_interp: impulse table plus step, gating and reset sequences against a convolution model.
// Revision: 1.0
`default_nettype none

module tb_cic_interp;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_en;
  logic signed [7:0] i_data;
  logic              o_req;
  logic [15:0]       o_data;
  logic              o_valid;

  cic_interp dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_data  (i_data),
    .o_req   (o_req),
    .o_data  (o_data),
    .o_valid (o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic              en;
    logic signed [7:0] data;
    logic              req;
    logic [15:0]       out;
    logic              valid;
  } vec_t;

  // (1+z^-1+z^-2+z^-3)^5
  int h [16] = '{1, 5, 15, 35, 65, 101, 135, 155, 155, 135, 101, 65, 35, 15, 5, 1};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          up_q [$];
  int          m_phase;
  logic [15:0] m_out;
  vec_t        vecs [26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] conv();
    int j = up_q.size() - 1 - 6;
    int s = 0;
    for (int k = 0; k < 16; k++) begin
      if (j - k >= 0) s += h[k] * up_q[j-k];
    end
    return 16'(s);
  endfunction

  task automatic model_reset();
    up_q.delete();
    m_phase = 0;
    m_out   = '0;
  endtask

  task automatic apply(input string tag, input logic en, input logic signed [7:0] d,
                       input logic ereq, input logic [15:0] eout, input logic evalid);
    i_en   = en;
    i_data = d;
    @(negedge i_clk);
    check({tag, "/req"}, 32'(o_req), 32'(ereq));
    @(posedge i_clk);
    #1;
    check({tag, "/data"}, 32'(o_data), 32'(eout));
    check({tag, "/valid"}, 32'(o_valid), 32'(evalid));
  endtask

  task automatic drive(input string tag, input logic en, input logic signed [7:0] d);
    logic ereq;
    ereq = en && (m_phase == 0);
    if (en) begin
      up_q.push_back(ereq ? int'(d) : 0);
      m_phase = (m_phase + 1) % 4;
      m_out   = conv();
    end
    apply(tag, en, d, ereq, m_out, en);
  endtask

  // Entered just after a rising edge; assertion is checked before the next edge.
  task automatic pulse_reset(input string tag);
    i_rst_n = 1'b0;
    #1;
    check({tag, "/rst_data"}, 32'(o_data), 32'h0);
    check({tag, "/rst_valid"}, 32'(o_valid), 32'h0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_en    = 1'b1;
    i_data  = 8'sh7f;
    model_reset();

    // Reset held with enable and full-scale data present
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk);
      #1;
      check("reset/data", 32'(o_data), 32'h0);
      check("reset/valid", 32'(o_valid), 32'h0);
    end
    i_rst_n = 1'b1;

    // Impulse response straight out of reset
    for (int i = 0; i < 26; i++) begin
      vecs[i].en    = 1'b1;
      vecs[i].data  = (i == 0) ? 8'sd1 : 8'sd0;
      vecs[i].req   = (i % 4 == 0);
      vecs[i].out   = (i >= 6 && i < 22) ? 16'(h[i-6]) : 16'h0;
      vecs[i].valid = 1'b1;
    end
    for (int i = 0; i < 26; i++) begin
      apply($sformatf("impulse[%0d]", i), vecs[i].en, vecs[i].data,
            vecs[i].req, vecs[i].out, vecs[i].valid);
    end

    // Positive full-scale step
    pulse_reset("pstep");
    for (int c = 0; c < 40; c++) drive("pstep", 1'b1, 8'sh7f);
    for (int c = 0; c < 8; c++) begin
      drive("pstep_flat", 1'b1, 8'sh7f);
      check("pstep_final", 32'(o_data), 32'h7f00);
    end

    // Negative full-scale step wraps internally
    pulse_reset("nstep");
    for (int c = 0; c < 40; c++) drive("nstep", 1'b1, -8'sd128);
    check("nstep_final", 32'(o_data), 32'h8000);

    // Enable gating; data off-request cycles is noise and must be ignored
    pulse_reset("gate");
    for (int c = 0; c < 120; c++) begin
      logic en;
      en = ($urandom_range(0, 3) != 0);
      drive("gate", en, (m_phase == 0) ? 8'sh7f : 8'(-$urandom_range(1, 100)));
    end
    for (int c = 0; c < 24; c++) drive("gate_tail", 1'b1, 8'sh7f);
    check("gate_final", 32'(o_data), 32'h7f00);

    // Reset during the ramp restarts from zero
    pulse_reset("mid");
    for (int c = 0; c < 11; c++) drive("mid_pre", 1'b1, 8'sh7f);
    pulse_reset("mid_hit");
    for (int c = 0; c < 30; c++) drive("mid_post", 1'b1, 8'sh7f);
    check("mid_final", 32'(o_data), 32'h7f00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
